// File: rtl/byte_word_packer.sv
// byte_word_packer: packs a byte stream into wide words with valid/ready output, idle flush and overflow flag
module byte_word_packer #(
  parameter int BYTE_W     = 8,
  parameter int N_BYTES    = 4,
  parameter int LITTLE_END = 1,
  parameter int TIMEOUT    = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [BYTE_W-1:0]             dato,
  input  logic                          rx_flat,
  input  logic                          clear,
  input  logic                          word_ready,
  output logic [BYTE_W*N_BYTES-1:0]     data_comple,
  output logic                          flat_comple,
  output logic [$clog2(N_BYTES+1)-1:0]  word_bytes,
  output logic                          partial,
  output logic                          overflow
);
  localparam int IW = $clog2(N_BYTES);
  localparam int CW = $clog2(N_BYTES + 1);
  localparam int TW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [IW-1:0] LAST = IW'(N_BYTES - 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);

  logic [N_BYTES-1:0][BYTE_W-1:0] slots_q, slots_d;
  logic [IW-1:0]                  cnt_q, cnt_d;
  logic [TW-1:0]                  idle_q, idle_d;
  logic [BYTE_W*N_BYTES-1:0]      data_q, data_d, word;
  logic                           flat_q, flat_d, part_q, part_d, ovf_q, ovf_d;
  logic [CW-1:0]                  wb_q, wb_d;
  logic                           out_free, accept, store, full_ld, drop, flush, load;

  assign out_free = !flat_q || word_ready;
  assign accept   = rx_flat && !clear;
  assign store    = accept && cnt_q != LAST;
  assign full_ld  = accept && cnt_q == LAST && out_free;
  assign drop     = accept && cnt_q == LAST && !out_free;
  assign flush    = TIMEOUT > 0 && !clear && !rx_flat && cnt_q != '0 && idle_q == TMAX && out_free;
  assign load     = full_ld || flush;

  // Unfilled slots read as zero so a flushed partial word never carries stale bytes.
  for (genvar k = 0; k < N_BYTES; k++) begin : g_slot
    localparam int P = LITTLE_END != 0 ? k : N_BYTES - 1 - k;
    logic [BYTE_W-1:0] b;
    assign b = IW'(k) < cnt_q ? slots_q[k] : (IW'(k) == cnt_q && full_ld) ? dato : '0;
    assign word[P*BYTE_W +: BYTE_W] = b;
  end

  always_comb begin
    slots_d = slots_q;
    if (store) slots_d[cnt_q] = dato;
    cnt_d  = (clear || load) ? '0 : store ? cnt_q + 1'b1 : cnt_q;
    idle_d = (clear || load || store || cnt_q == '0) ? '0
           : (TIMEOUT > 0 && !rx_flat && idle_q != TMAX) ? idle_q + 1'b1 : idle_q;
    flat_d = load || (flat_q && !word_ready);
    data_d = load ? word : data_q;
    wb_d   = full_ld ? CW'(N_BYTES) : flush ? CW'(cnt_q) : wb_q;
    part_d = load ? flush : part_q;
    ovf_d  = clear ? 1'b0 : drop ? 1'b1 : ovf_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slots_q <= '0;
      cnt_q   <= '0;
      idle_q  <= '0;
      data_q  <= '0;
      flat_q  <= 1'b0;
      wb_q    <= '0;
      part_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      slots_q <= slots_d;
      cnt_q   <= cnt_d;
      idle_q  <= idle_d;
      data_q  <= data_d;
      flat_q  <= flat_d;
      wb_q    <= wb_d;
      part_q  <= part_d;
      ovf_q   <= ovf_d;
    end
  end

  assign data_comple = data_q;
  assign flat_comple = flat_q;
  assign word_bytes  = wb_q;
  assign partial     = part_q;
  assign overflow    = ovf_q;
endmodule

// File: tb/tb_byte_word_packer.sv
// tb_byte_word_packer: random and directed stimulus against a byte-queue reference model,
// two instances (little-endian with timeout 4, big-endian without timeout) sharing inputs
module tb_byte_word_packer;
  logic        clk = 1'b0, rst = 1'b0;
  logic [7:0]  dato = '0;
  logic        rx_flat = 1'b0, clear = 1'b0, word_ready = 1'b0;
  logic [31:0] data_le, data_be;
  logic        flat_le, flat_be, part_le, part_be, ovf_le, ovf_be;
  logic [2:0]  wb_le, wb_be;

  always #5 clk = ~clk;

  byte_word_packer #(.BYTE_W(8), .N_BYTES(4), .LITTLE_END(1), .TIMEOUT(4)) u_le (
    .clk(clk), .rst(rst), .dato(dato), .rx_flat(rx_flat), .clear(clear), .word_ready(word_ready),
    .data_comple(data_le), .flat_comple(flat_le), .word_bytes(wb_le), .partial(part_le), .overflow(ovf_le));

  byte_word_packer #(.BYTE_W(8), .N_BYTES(4), .LITTLE_END(0), .TIMEOUT(0)) u_be (
    .clk(clk), .rst(rst), .dato(dato), .rx_flat(rx_flat), .clear(clear), .word_ready(word_ready),
    .data_comple(data_be), .flat_comple(flat_be), .word_bytes(wb_be), .partial(part_be), .overflow(ovf_be));

  int checks = 0, errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // reference model state, index 0 = little-endian/timeout 4, index 1 = big-endian/no timeout
  int          mn[2], midle[2], mb[2];
  logic [7:0]  acc[2][4];
  logic [31:0] mw[2];
  bit          mv[2], mp[2], mo[2];

  function automatic int to_of(input int m);
    return m == 0 ? 4 : 0;
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      mn[m] = 0; midle[m] = 0; mb[m] = 0; mw[m] = '0; mv[m] = 0; mp[m] = 0; mo[m] = 0;
    end
  endtask

  task automatic emit(input int m, input int cnt, input bit part);
    logic [31:0] w = '0;
    for (int k = 0; k < cnt; k++) begin
      int pos = (m == 0) ? k : 3 - k;
      w = w | (32'(acc[m][k]) << (8 * pos));
    end
    mw[m] = w; mv[m] = 1; mb[m] = cnt; mp[m] = part; mn[m] = 0; midle[m] = 0;
  endtask

  task automatic model_step(input int m);
    bit free = !mv[m] || word_ready;
    bit load = 0;
    if (clear) begin
      mn[m] = 0; midle[m] = 0; mo[m] = 0;
    end else if (rx_flat) begin
      if (mn[m] < 3) begin
        acc[m][mn[m]] = dato; mn[m]++; midle[m] = 0;
      end else if (free) begin
        acc[m][3] = dato; emit(m, 4, 0); load = 1;
      end else mo[m] = 1;
    end else if (to_of(m) > 0 && mn[m] > 0) begin
      if (midle[m] == to_of(m) && free) begin
        emit(m, mn[m], 1); load = 1;
      end else if (midle[m] < to_of(m)) midle[m]++;
    end
    if (!load && mv[m] && word_ready) mv[m] = 0;
  endtask

  task automatic compare();
    check("le_data", data_le, mw[0]);
    check("le_flat", 32'(flat_le), 32'(mv[0]));
    check("le_bytes", 32'(wb_le), 32'(mb[0]));
    check("le_partial", 32'(part_le), 32'(mp[0]));
    check("le_overflow", 32'(ovf_le), 32'(mo[0]));
    check("be_data", data_be, mw[1]);
    check("be_flat", 32'(flat_be), 32'(mv[1]));
    check("be_bytes", 32'(wb_be), 32'(mb[1]));
    check("be_partial", 32'(part_be), 32'(mp[1]));
    check("be_overflow", 32'(ovf_be), 32'(mo[1]));
  endtask

  task automatic cyc(input bit rx, input logic [7:0] d, input bit rdy, input bit clr);
    rx_flat = rx; dato = d; word_ready = rdy; clear = clr;
    @(posedge clk);
    model_step(0);
    model_step(1);
    @(negedge clk);
    compare();
  endtask

  task automatic do_reset();
    rx_flat = 0; clear = 0; rst = 0;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    compare();
    rst = 1;
  endtask

  initial begin
    do_reset();
    // little/big endian assembly with ready held high
    cyc(1, 8'h11, 1, 0); cyc(1, 8'h22, 1, 0); cyc(1, 8'h33, 1, 0); cyc(1, 8'h44, 1, 0);
    check("t1_le_word", data_le, 32'h44332211);
    check("t2_be_word", data_be, 32'h11223344);
    check("t1_flat", 32'(flat_le), 32'd1);
    check("t1_bytes", 32'(wb_le), 32'd4);
    cyc(0, 8'h00, 1, 0);
    check("t1_flat_fall", 32'(flat_le), 32'd0);
    check("t1_data_hold", data_le, 32'h44332211);
    // backpressure and overflow
    for (int i = 1; i <= 8; i++) cyc(1, 8'(i), 0, 0);
    check("t3_held", data_le, 32'h04030201);
    check("t3_overflow", 32'(ovf_le), 32'd1);
    cyc(1, 8'h09, 1, 0);
    check("t3_next_word", data_le, 32'h09070605);
    check("t3_next_be", data_be, 32'h05060709);
    cyc(0, 8'h00, 1, 1);
    check("clear_ovf", 32'(ovf_le), 32'd0);
    // idle timeout flush of a partial word
    cyc(1, 8'hAA, 1, 0); cyc(1, 8'hBB, 1, 0);
    for (int i = 0; i < 5; i++) cyc(0, 8'h00, 1, 0);
    check("t4_word", data_le, 32'h0000BBAA);
    check("t4_bytes", 32'(wb_le), 32'd2);
    check("t4_partial", 32'(part_le), 32'd1);
    check("t4_no_flush_be", 32'(flat_be), 32'd0);
    cyc(0, 8'h00, 1, 1);
    // reset in mid-word
    cyc(1, 8'h55, 1, 0); cyc(1, 8'h66, 1, 0);
    do_reset();
    check("t5_reset_data", data_le, 32'h0);
    for (int i = 1; i <= 4; i++) cyc(1, 8'(i), 1, 0);
    check("t5_word", data_le, 32'h04030201);
    // back-to-back words
    for (int i = 1; i <= 8; i++) begin
      cyc(1, 8'(8'h20 + i), 1, 0);
      if (i == 4) check("t6_word0", data_le, 32'h24232221);
    end
    check("t6_word1", data_le, 32'h28272625);
    check("t6_overflow", 32'(ovf_le), 32'd0);
    // randomized segments with varying byte density
    for (int s = 0; s < 12; s++) begin
      int dens = $urandom_range(15, 100);
      int rdy_p = $urandom_range(20, 90);
      for (int i = 0; i < 200; i++)
        cyc($urandom_range(0, 99) < dens, 8'($urandom), $urandom_range(0, 99) < rdy_p,
            $urandom_range(0, 99) < 2);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
